// File: rtl/ped_button_conditioner.sv
// Pedestrian push-button front end: synchroniser, debouncer, request FSM,
// WAIT lamp driver and saturating count of accepted presses.
// Optional build macro: WAIT_LAMP_BLINK_EN makes the WAIT lamp blink at 1 Hz
// while a request is pending. Without it, the lamp is steady on.
`timescale 1ns/1ps

module ped_button_conditioner #(
    parameter int DEBOUNCE_MS = 20,
    parameter int LOCKOUT_MS  = 5000,
    parameter int CNT_W       = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       button_raw,
    input  logic       ped_walk,
    output logic       button,
    output logic       wait_lamp,
    output logic [7:0] press_count
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_MS - 1);
    localparam logic [CNT_W-1:0] LO_LAST = (LOCKOUT_MS > 0) ? CNT_W'(LOCKOUT_MS - 1) : '0;

    typedef enum logic [1:0] {IDLE, REQ, SERVE, LOCKOUT} state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic             s1_p0, s2_p1;
    logic             db_p2, db_q_p3;
    logic [CNT_W-1:0] dcnt;
    logic             press;
    state_t           state, state_n;
    logic [CNT_W-1:0] lcnt, lcnt_n;
    logic [7:0]       count_n;

    // Stage p0/p1: two-flop synchroniser on the asynchronous contact
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_p0 <= 1'b0;
            s2_p1 <= 1'b0;
        end else begin
            s1_p0 <= button_raw;
            s2_p1 <= s1_p0;
        end
    end

    // Stage p2: debounced level follows s2 only after it has differed for DEBOUNCE_MS cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            db_p2 <= 1'b0;
            dcnt  <= '0;
        end else if (s2_p1 != db_p2) begin
            if (dcnt == DB_LAST) begin
                db_p2 <= s2_p1;
                dcnt  <= '0;
            end else begin
                dcnt <= dcnt + CNT_W'(1);
            end
        end else begin
            dcnt <= '0;
        end
    end

    // Stage p3: delayed debounced level for rising-edge detection
    always_ff @(posedge clk) begin
        if (rst) db_q_p3 <= 1'b0;
        else     db_q_p3 <= db_p2;
    end

    assign press = db_p2 & ~db_q_p3;

    // Request FSM state, lockout counter and press counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            lcnt        <= '0;
            press_count <= 8'd0;
        end else begin
            state       <= state_n;
            lcnt        <= lcnt_n;
            press_count <= count_n;
        end
    end

    // Next-state logic; ped_walk always wins over a press in the same cycle
    always_comb begin
        state_n = state;
        lcnt_n  = '0;
        count_n = press_count;
        unique case (state)
            IDLE: begin
                if (ped_walk) begin
                    state_n = SERVE;
                end else if (press) begin
                    state_n = REQ;
                    count_n = sat_inc8(press_count);
                end
            end
            REQ: begin
                if (ped_walk) state_n = SERVE;
            end
            SERVE: begin
                if (!ped_walk) state_n = (LOCKOUT_MS == 0) ? IDLE : LOCKOUT;
            end
            LOCKOUT: begin
                lcnt_n = lcnt + CNT_W'(1);
                if (ped_walk) begin
                    state_n = SERVE;
                    lcnt_n  = '0;
                end else if (lcnt == LO_LAST) begin
                    state_n = IDLE;
                    lcnt_n  = '0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign button = (state == REQ);

`ifdef WAIT_LAMP_BLINK_EN
    logic [8:0] blink_cnt;
    logic       blink_lvl;

    // 1 Hz blink phase: starts lit on REQ entry, toggles every 500 cycles, clears outside REQ
    always_ff @(posedge clk) begin
        if (rst || state_n != REQ) begin
            blink_cnt <= 9'd0;
            blink_lvl <= 1'b0;
        end else if (state != REQ) begin
            blink_cnt <= 9'd0;
            blink_lvl <= 1'b1;
        end else if (blink_cnt == 9'd499) begin
            blink_cnt <= 9'd0;
            blink_lvl <= ~blink_lvl;
        end else begin
            blink_cnt <= blink_cnt + 9'd1;
        end
    end

    assign wait_lamp = (state == REQ) && blink_lvl;
`else
    assign wait_lamp = (state == REQ);
`endif

endmodule

// File: tb/tb_ped_button_conditioner.sv
// Directed bench for ped_button_conditioner with DEBOUNCE_MS=4, LOCKOUT_MS=10.
`timescale 1ns/1ps

module tb_ped_button_conditioner;

    logic       clk;
    logic       rst;
    logic       button_raw;
    logic       ped_walk;
    logic       button;
    logic       wait_lamp;
    logic [7:0] press_count;

    int total;
    int bad;

    ped_button_conditioner #(
        .DEBOUNCE_MS(4),
        .LOCKOUT_MS (10),
        .CNT_W      (20)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .button_raw (button_raw),
        .ped_walk   (ped_walk),
        .button     (button),
        .wait_lamp  (wait_lamp),
        .press_count(press_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        button_raw = 1'b0;
        ped_walk   = 1'b0;
        step(3);
        rst = 1'b0;
    endtask

    // One complete press: request, serve, lockout, back to IDLE
    task automatic accept_press();
        button_raw = 1'b1;
        step(8);
        button_raw = 1'b0;
        step(7);
        ped_walk = 1'b1;
        step(1);
        ped_walk = 1'b0;
        step(12);
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        button_raw = 1'b1;
        ped_walk   = 1'b0;
        step(3);
        total++; if (button !== 1'b0) begin bad++; $display("FAIL reset_button got=%b want=0", button); end
        total++; if (wait_lamp !== 1'b0) begin bad++; $display("FAIL reset_wait_lamp got=%b want=0", wait_lamp); end
        total++; if (press_count !== 8'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", press_count); end
        rst = 1'b0;
        step(6);
        total++; if (button !== 1'b0) begin bad++; $display("FAIL latency_early got=%b want=0", button); end
        step(1);
        total++; if (button !== 1'b1) begin bad++; $display("FAIL latency_button got=%b want=1", button); end
        total++; if (press_count !== 8'd1) begin bad++; $display("FAIL latency_count got=%0d want=1", press_count); end
    endtask

    task automatic test_bounce();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            button_raw = 1'b1;
            step(3);
            button_raw = 1'b0;
            step(1);
        end
        step(6);
        total++; if (button !== 1'b0) begin bad++; $display("FAIL bounce_button got=%b want=0", button); end
        total++; if (press_count !== 8'd0) begin bad++; $display("FAIL bounce_count got=%0d want=0", press_count); end
    endtask

    task automatic test_clean_press();
        do_reset();
        button_raw = 1'b1;
        step(7);
        total++; if (button !== 1'b1) begin bad++; $display("FAIL press_button got=%b want=1", button); end
        total++; if (wait_lamp !== 1'b1) begin bad++; $display("FAIL press_wait_lamp got=%b want=1", wait_lamp); end
        total++; if (press_count !== 8'd1) begin bad++; $display("FAIL press_count got=%0d want=1", press_count); end
        step(13);
        total++; if (press_count !== 8'd1) begin bad++; $display("FAIL held_count got=%0d want=1", press_count); end
        total++; if (button !== 1'b1) begin bad++; $display("FAIL held_button got=%b want=1", button); end
        button_raw = 1'b0;
        ped_walk   = 1'b1;
        step(1);
        total++; if (button !== 1'b0) begin bad++; $display("FAIL serve_button got=%b want=0", button); end
        total++; if (wait_lamp !== 1'b0) begin bad++; $display("FAIL serve_wait_lamp got=%b want=0", wait_lamp); end
        step(8);
        total++; if (button !== 1'b0) begin bad++; $display("FAIL serve_hold_button got=%b want=0", button); end
    endtask

    // Continues from the SERVE state left by test_clean_press
    task automatic test_lockout();
        ped_walk   = 1'b0;
        button_raw = 1'b1;
        step(15);
        total++; if (button !== 1'b0) begin bad++; $display("FAIL lockout_button got=%b want=0", button); end
        total++; if (press_count !== 8'd1) begin bad++; $display("FAIL lockout_count got=%0d want=1", press_count); end
        button_raw = 1'b0;
        step(7);
        button_raw = 1'b1;
        step(7);
        total++; if (button !== 1'b1) begin bad++; $display("FAIL after_lockout_button got=%b want=1", button); end
        total++; if (press_count !== 8'd2) begin bad++; $display("FAIL after_lockout_count got=%0d want=2", press_count); end
        button_raw = 1'b0;
    endtask

    task automatic test_lockout_edge();
        do_reset();
        button_raw = 1'b1; step(8);
        button_raw = 1'b0; step(7);
        ped_walk = 1'b1; step(1);
        ped_walk = 1'b0; step(4);
        button_raw = 1'b1;
        step(12);
        total++; if (button !== 1'b0) begin bad++; $display("FAIL edge_last_lockout_button got=%b want=0", button); end
        total++; if (press_count !== 8'd1) begin bad++; $display("FAIL edge_last_lockout_count got=%0d want=1", press_count); end
        do_reset();
        button_raw = 1'b1; step(8);
        button_raw = 1'b0; step(7);
        ped_walk = 1'b1; step(1);
        ped_walk = 1'b0; step(5);
        button_raw = 1'b1;
        step(6);
        total++; if (button !== 1'b0) begin bad++; $display("FAIL edge_first_idle_early got=%b want=0", button); end
        step(1);
        total++; if (button !== 1'b1) begin bad++; $display("FAIL edge_first_idle_button got=%b want=1", button); end
        total++; if (press_count !== 8'd2) begin bad++; $display("FAIL edge_first_idle_count got=%0d want=2", press_count); end
        button_raw = 1'b0;
    endtask

    task automatic test_press_vs_walk();
        do_reset();
        button_raw = 1'b1;
        step(6);
        ped_walk = 1'b1;
        step(1);
        total++; if (button !== 1'b0) begin bad++; $display("FAIL collide_button got=%b want=0", button); end
        total++; if (press_count !== 8'd0) begin bad++; $display("FAIL collide_count got=%0d want=0", press_count); end
        ped_walk = 1'b0;
        step(14);
        total++; if (button !== 1'b0) begin bad++; $display("FAIL held_no_rise_button got=%b want=0", button); end
        do_reset();
        button_raw = 1'b1;
        step(7);
        total++; if (button !== 1'b1) begin bad++; $display("FAIL pre_rst_button got=%b want=1", button); end
        rst        = 1'b1;
        button_raw = 1'b0;
        step(1);
        rst = 1'b0;
        total++; if (button !== 1'b0) begin bad++; $display("FAIL mid_rst_button got=%b want=0", button); end
        total++; if (wait_lamp !== 1'b0) begin bad++; $display("FAIL mid_rst_wait_lamp got=%b want=0", wait_lamp); end
        total++; if (press_count !== 8'd0) begin bad++; $display("FAIL mid_rst_count got=%0d want=0", press_count); end
    endtask

    task automatic test_saturation();
        logic exp_lamp;
        do_reset();
        for (int i = 1; i <= 256; i++) begin
            accept_press();
            if (i == 254) begin
                total++; if (press_count !== 8'd254) begin bad++; $display("FAIL count_254 got=%0d want=254", press_count); end
            end
            if (i == 255) begin
                total++; if (press_count !== 8'd255) begin bad++; $display("FAIL count_255 got=%0d want=255", press_count); end
            end
        end
        total++; if (press_count !== 8'd255) begin bad++; $display("FAIL count_256 got=%0d want=255", press_count); end
        button_raw = 1'b1;
        step(7);
        total++; if (press_count !== 8'd255) begin bad++; $display("FAIL count_257 got=%0d want=255", press_count); end
        for (int k = 0; k <= 1000; k++) begin
`ifdef WAIT_LAMP_BLINK_EN
            exp_lamp = (k < 500) || (k == 1000);
`else
            exp_lamp = 1'b1;
`endif
            if (k == 0 || k == 499 || k == 500 || k == 999 || k == 1000) begin
                total++;
                if (wait_lamp !== exp_lamp) begin
                    bad++;
                    $display("FAIL lamp_k%0d got=%b want=%b", k, wait_lamp, exp_lamp);
                end
            end
            step(1);
        end
        button_raw = 1'b0;
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        rst        = 1'b1;
        button_raw = 1'b0;
        ped_walk   = 1'b0;
        test_reset();
        test_bounce();
        test_clean_press();
        test_lockout();
        test_lockout_edge();
        test_press_vs_walk();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
